// File: rtl/rgb_led_pwm.sv
// Two-LED RGB PWM driver: off/steady/blink/breathe modes, ctrl shadowed at each frame wrap.
// Latency: one aclk cycle from PWM counter to pin; ctrl changes take effect at the next frame wrap.
// Backpressure: none; free-running. Breathe mode is built only with RGB_LED_PWM_BREATHE_EN.
module rgb_led_pwm #(
  parameter int PRESCALE_W   = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [31:0]           ctrl0,
  input  logic [31:0]           ctrl1,
  output logic                  rgb1_r,
  output logic                  rgb1_g,
  output logic                  rgb1_b,
  output logic                  rgb2_r,
  output logic                  rgb2_g,
  output logic                  rgb2_b,
  output logic                  frame_tick
);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_STEADY  = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;
  localparam logic [7:0] BLINK_LAST   = 8'(BLINK_FRAMES - 1);

  logic [PRESCALE_W-1:0] pcnt;
  logic [7:0]            wcnt;
  logic                  step;
  logic                  wrap;

  // Bits [31:26] of each control word carry no function.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^{ctrl0[31:26], ctrl1[31:26]};

  // >= compare so that lowering prescale below pcnt steps on the next cycle instead of overrunning.
  assign step = (pcnt >= prescale);
  assign wrap = step && (wcnt == 8'hFF);

  // Prescale counter: period prescale+1 cycles.
  always_ff @(posedge aclk) begin
    if (areset) begin
      pcnt <= '0;
    end else if (step) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRESCALE_W'(1);
    end
  end

  // PWM step counter, shared by both LEDs; wraps naturally 255 -> 0.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wcnt <= '0;
    end else if (step) begin
      wcnt <= wcnt + 8'd1;
    end
  end

  // Frame tick is registered, so it appears the cycle after the wrap.
  always_ff @(posedge aclk) begin
    if (areset) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_led
    logic [31:0] ctrl_w;
    logic [1:0]  mode_nx;
    logic [23:0] duty_sh;
    logic [1:0]  mode_sh;
    logic [7:0]  bcnt;
    logic        phase;
    logic [7:0]  duty_eff [3];
    logic [2:0]  pwm_q;

    assign ctrl_w  = (i == 0) ? ctrl0 : ctrl1;
    assign mode_nx = ctrl_w[25:24];

    // Shadow the control word only at a frame wrap so a frame never changes mid-way.
    always_ff @(posedge aclk) begin
      if (areset) begin
        duty_sh <= '0;
        mode_sh <= MODE_OFF;
      end else if (wrap) begin
        duty_sh <= ctrl_w[23:0];
        mode_sh <= mode_nx;
      end
    end

    // Blink frame counter: restart "on" when entering blink, toggle every BLINK_FRAMES frames.
    always_ff @(posedge aclk) begin
      if (areset) begin
        bcnt  <= '0;
        phase <= 1'b0;
      end else if (wrap && (mode_nx == MODE_BLINK)) begin
        if (mode_sh != MODE_BLINK) begin
          bcnt  <= '0;
          phase <= 1'b1;
        end else if (bcnt == BLINK_LAST) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + 8'd1;
        end
      end
    end

`ifdef RGB_LED_PWM_BREATHE_EN
    logic [7:0]  ramp;
    logic        ramp_down;
    logic [15:0] prod [3];

    // Triangle ramp 0..255..0, one step per frame; restarts at 0 going up when entering breathe.
    always_ff @(posedge aclk) begin
      if (areset) begin
        ramp      <= '0;
        ramp_down <= 1'b0;
      end else if (wrap && (mode_nx == MODE_BREATHE)) begin
        if (mode_sh != MODE_BREATHE) begin
          ramp      <= '0;
          ramp_down <= 1'b0;
        end else if (!ramp_down) begin
          if (ramp == 8'hFF) begin
            ramp      <= 8'hFE;
            ramp_down <= 1'b1;
          end else begin
            ramp <= ramp + 8'd1;
          end
        end else begin
          if (ramp == 8'h00) begin
            ramp      <= 8'h01;
            ramp_down <= 1'b0;
          end else begin
            ramp <= ramp - 8'd1;
          end
        end
      end
    end

    // Brightness scaling: upper byte of duty * ramp.
    always_comb begin
      for (int c = 0; c < 3; c++) begin
        prod[c] = {8'h00, duty_sh[8*c +: 8]} * {8'h00, ramp};
      end
    end
`endif

    // Effective duty per channel from the shadowed mode.
    always_comb begin
      for (int c = 0; c < 3; c++) begin
        duty_eff[c] = 8'h00;
        case (mode_sh)
          MODE_OFF:    duty_eff[c] = 8'h00;
          MODE_STEADY: duty_eff[c] = duty_sh[8*c +: 8];
          MODE_BLINK:  duty_eff[c] = phase ? duty_sh[8*c +: 8] : 8'h00;
`ifdef RGB_LED_PWM_BREATHE_EN
          MODE_BREATHE: duty_eff[c] = prod[c][15:8];
`else
          MODE_BREATHE: duty_eff[c] = duty_sh[8*c +: 8];
`endif
          default:     duty_eff[c] = 8'h00;
        endcase
      end
    end

    // Registered PWM compare; bit 0 red, 1 green, 2 blue.
    always_ff @(posedge aclk) begin
      if (areset) begin
        pwm_q <= '0;
      end else begin
        for (int c = 0; c < 3; c++) begin
          pwm_q[c] <= (wcnt < duty_eff[c]);
        end
      end
    end
  end

  assign rgb1_r = g_led[0].pwm_q[0];
  assign rgb1_g = g_led[0].pwm_q[1];
  assign rgb1_b = g_led[0].pwm_q[2];
  assign rgb2_r = g_led[1].pwm_q[0];
  assign rgb2_g = g_led[1].pwm_q[1];
  assign rgb2_b = g_led[1].pwm_q[2];

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Bench for rgb_led_pwm: per-frame high-time counts and frame_tick timing against expected tables.
// Expected frames are queued when stimulus is applied and popped after each measured frame.
// Built with BLINK_FRAMES=4; breathe expectations follow RGB_LED_PWM_BREATHE_EN.
module tb_rgb_led_pwm;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] prescale;
  logic [31:0] ctrl0, ctrl1;
  logic        rgb1_r, rgb1_g, rgb1_b, rgb2_r, rgb2_g, rgb2_b, frame_tick;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    int          ps;
    logic [31:0] c0;
    logic [31:0] c1;
    int          r1, g1, b1, r2, g2, b2;
  } vec_t;

  typedef struct {
    string name;
    int    r1, g1, b1, r2, g2, b2;
    int    ticks, tick_pos;
  } frame_t;

  frame_t sb_q[$];
  frame_t m;
  vec_t   vecs[5];

  always #5 aclk = ~aclk;

  rgb_led_pwm #(.PRESCALE_W(16), .BLINK_FRAMES(4)) dut (
    .aclk(aclk), .areset(areset), .prescale(prescale), .ctrl0(ctrl0), .ctrl1(ctrl1),
    .rgb1_r(rgb1_r), .rgb1_g(rgb1_g), .rgb1_b(rgb1_b),
    .rgb2_r(rgb2_r), .rgb2_g(rgb2_g), .rgb2_b(rgb2_b),
    .frame_tick(frame_tick)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic int all_outs();
    return int'({rgb1_r, rgb1_g, rgb1_b, rgb2_r, rgb2_g, rgb2_b, frame_tick});
  endfunction

  task automatic expect_frame(input string nm, input int r1, input int g1, input int b1,
                              input int r2, input int g2, input int b2, input int len);
    frame_t f;
    f.name = nm; f.r1 = r1; f.g1 = g1; f.b1 = b1; f.r2 = r2; f.g2 = g2; f.b2 = b2;
    f.ticks = 1; f.tick_pos = len - 1;
    sb_q.push_back(f);
  endtask

  // Count high cycles per output over one frame; optionally rewrite ctrl0 at sample index chg_at.
  task automatic measure(input int len, input int chg_at, input logic [31:0] new_c0);
    m.name = ""; m.r1 = 0; m.g1 = 0; m.b1 = 0; m.r2 = 0; m.g2 = 0; m.b2 = 0;
    m.ticks = 0; m.tick_pos = -1;
    for (int i = 0; i < len; i++) begin
      @(negedge aclk);
      m.r1 += int'(rgb1_r); m.g1 += int'(rgb1_g); m.b1 += int'(rgb1_b);
      m.r2 += int'(rgb2_r); m.g2 += int'(rgb2_g); m.b2 += int'(rgb2_b);
      if (frame_tick) begin
        m.ticks++;
        m.tick_pos = i;
      end
      if (i == chg_at) ctrl0 = new_c0;
    end
  endtask

  task automatic check_frame();
    frame_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({e.name, " rgb1_r"}, m.r1, e.r1);
      check({e.name, " rgb1_g"}, m.g1, e.g1);
      check({e.name, " rgb1_b"}, m.b1, e.b1);
      check({e.name, " rgb2_r"}, m.r2, e.r2);
      check({e.name, " rgb2_g"}, m.g2, e.g2);
      check({e.name, " rgb2_b"}, m.b2, e.b2);
      check({e.name, " ticks"}, m.ticks, e.ticks);
      check({e.name, " tick_pos"}, m.tick_pos, e.tick_pos);
    end
  endtask

  task automatic wait_tick(input string nm, input int budget);
    int found = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge aclk);
      if (frame_tick) begin
        found = 1;
        break;
      end
    end
    check({nm, " tick_wait"}, found, 1);
  endtask

  task automatic do_reset(input string nm, input int ps, input logic [31:0] c0, input logic [31:0] c1);
    areset   = 1'b1;
    prescale = 16'(ps);
    ctrl0    = c0;
    ctrl1    = c1;
    repeat (3) @(negedge aclk);
    check({nm, " reset_outs"}, all_outs(), 0);
    areset = 1'b0;
  endtask

  initial begin
    int len;
    int exp_b;
    areset = 1'b1; prescale = '0; ctrl0 = '0; ctrl1 = '0;

    vecs[0] = '{"steady_r64",  0, 32'h0100_0040, 32'h0000_0000, 64, 0, 0, 0, 0, 0};
    vecs[1] = '{"b2_ps3",      3, 32'h0000_0000, 32'h01FF_0000, 0, 0, 0, 0, 0, 1020};
    vecs[2] = '{"mode0_off",   0, 32'h00FF_FFFF, 32'h00FF_FFFF, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{"mixed_ps1",   1, 32'h0180_4020, 32'h0101_FF00, 64, 128, 256, 0, 510, 2};
    vecs[4] = '{"ignored_bits",0, 32'hFD00_0010, 32'h0200_0020, 16, 0, 0, 32, 0, 0};

    for (int v = 0; v < 5; v++) begin
      len = 256 * (vecs[v].ps + 1);
      do_reset(vecs[v].name, vecs[v].ps, vecs[v].c0, vecs[v].c1);
      wait_tick(vecs[v].name, len + 16);
      expect_frame(vecs[v].name, vecs[v].r1, vecs[v].g1, vecs[v].b1,
                   vecs[v].r2, vecs[v].g2, vecs[v].b2, len);
      measure(len, -1, 32'h0);
      check_frame();
    end

    // Mid-frame ctrl change at wcnt=100 must wait for the next frame.
    do_reset("midframe", 0, 32'h0100_0010, 32'h0);
    wait_tick("midframe", 272);
    expect_frame("midframe_keep", 16, 0, 0, 0, 0, 0, 256);
    measure(256, 100, 32'h0100_00F0);
    check_frame();
    expect_frame("midframe_next", 240, 0, 0, 0, 0, 0, 256);
    measure(256, -1, 32'h0);
    check_frame();

    // Blink: green at 128 for 4 frames, off for 4, on again.
    do_reset("blink", 0, 32'h0200_8000, 32'h0);
    wait_tick("blink", 272);
    for (int f = 0; f < 12; f++) begin
      expect_frame($sformatf("blink_f%0d", f), 0, ((f / 4) % 2 == 0) ? 128 : 0, 0, 0, 0, 0, 256);
      measure(256, -1, 32'h0);
      check_frame();
    end

    // Reset pulse at wcnt=77 in a lit frame.
    do_reset("rst77", 0, 32'h0100_00FF, 32'h0);
    wait_tick("rst77", 272);
    repeat (77) @(negedge aclk);
    check("rst77 pre_reset_r1", int'(rgb1_r), 1);
    areset = 1'b1;
    @(negedge aclk);
    check("rst77 outs_after_reset", all_outs(), 0);
    areset = 1'b0;
    expect_frame("rst77_dark", 0, 0, 0, 0, 0, 0, 256);
    measure(256, -1, 32'h0);
    check_frame();
    expect_frame("rst77_lit", 255, 0, 0, 0, 0, 0, 256);
    measure(256, -1, 32'h0);
    check_frame();

    // Breathe (mode 3) with full red duty.
    do_reset("breathe", 0, 32'h0300_00FF, 32'h0);
    wait_tick("breathe", 272);
    for (int k = 0; k < 6; k++) begin
`ifdef RGB_LED_PWM_BREATHE_EN
      exp_b = (255 * k) >> 8;
`else
      exp_b = 255;
`endif
      expect_frame($sformatf("breathe_f%0d", k), exp_b, 0, 0, 0, 0, 0, 256);
      measure(256, -1, 32'h0);
      check_frame();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rgb_led_pwm.md
RGB_LED_PWM -- requirements
Module: rgb_led_pwm

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16, width of the prescale input and the prescale counter.
REQ-002 SHALL have parameter BLINK_FRAMES, default 64, number of PWM frames per blink half-period; legal range 1-255.
REQ-003 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port areset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port prescale  input  PRESCALE_W  aclk cycles per PWM step minus one; taken from a register-file word.
REQ-006 SHALL have port ctrl0  input  32  LED1 control: [7:0] R duty, [15:8] G duty, [23:16] B duty, [25:24] mode (0 off, 1 steady, 2 blink, 3 breathe), [31:26] ignored.
REQ-007 SHALL have port ctrl1  input  32  LED2 control; same layout as ctrl0.
REQ-008 SHALL have ports rgb1_r, rgb1_g, rgb1_b  output  1 each  LED1 drive, active-high.
REQ-009 SHALL have ports rgb2_r, rgb2_g, rgb2_b  output  1 each  LED2 drive, active-high.
REQ-010 SHALL have port frame_tick  output  1  one-cycle pulse at each PWM frame wrap.

Function
REQ-011 SHALL run prescale counter pcnt: at each cycle, if pcnt >= prescale then pcnt <= 0 and step asserts for that cycle; else pcnt <= pcnt+1.
REQ-012 SHALL give a step period of prescale+1 cycles; prescale=0 asserts step every cycle.
REQ-013 SHALL apply a prescale reduction below the current pcnt by stepping on the next cycle (>= compare); no counter overrun.
REQ-014 SHALL run 8-bit PWM counter wcnt, incremented on step, wrapping 255 -> 0.
REQ-015 SHALL define frame wrap as step with wcnt==255; frame_tick SHALL be registered and assert the cycle after the wrap.
REQ-016 SHALL copy ctrl0/ctrl1 into shadow registers only at frame wrap; mid-frame changes of ctrl SHALL NOT affect outputs until the next frame.
REQ-017 SHALL compute each channel output as (wcnt < duty_eff), registered: one cycle of latency from wcnt to pin.
REQ-018 SHALL give duty 0 -> output constantly 0; duty 255 -> high 255 of 256 steps.
REQ-019 SHALL force duty_eff=0 for mode 0, and use duty_eff=shadow duty for mode 1.
REQ-020 SHALL provide, in mode 2, a per-LED 8-bit frame counter; blink phase toggles when the counter reaches BLINK_FRAMES-1 and then clears; duty_eff = phase ? duty : 0.
REQ-021 SHALL start the blink phase at 1 (on), with counter 0, when the mode shadow changes into 2.
REQ-022 SHALL, in mode 3, drive an 8-bit triangle ramp per LED, updated at each frame wrap: up 0->255, then down 255->0, repeating; duty_eff = (duty * ramp) >> 8 (16-bit product, upper byte).
REQ-023 SHALL restart the ramp at 0 going up when the mode shadow changes into 3.
REQ-024 SHALL treat the two LEDs fully independently, apart from the shared pcnt/wcnt.

Reset
REQ-025 SHALL, on areset, clear pcnt, wcnt, shadows, blink counters, phases and ramps.
REQ-026 SHALL drive all six LED outputs and frame_tick 0 on the cycle after areset is sampled high, and hold them 0 while areset is high.
REQ-027 SHALL, on reset mid-frame, start the first frame from wcnt=0 after release; outputs remain 0 until the first frame wrap loads the shadows.

Configuration
REQ-028 SHALL compile the breathe logic (ramp registers, multiplier) only when macro RGB_LED_PWM_BREATHE_EN is defined.
REQ-029 SHALL, without RGB_LED_PWM_BREATHE_EN, treat mode 3 exactly as mode 1 (steady) and instantiate no ramp or multiplier logic.

Verification
REQ-030 SHALL cover: prescale=0, ctrl0=0x0100_0040 -> rgb1_r high 64 of every 256 cycles, frame_tick every 256 cycles, rgb1_g/b and LED2 low.
REQ-031 SHALL cover: prescale=3, ctrl1=0x01FF_0000 -> rgb2_b high 1020 of every 1024 cycles; frame_tick period 1024.
REQ-032 SHALL cover: ctrl0 changed from duty 0x10 to 0xF0 at wcnt=100 -> current frame keeps 0x10, next frame shows 0xF0.
REQ-033 SHALL cover: prescale=0, BLINK_FRAMES=4, ctrl0=0x0200_8000 mode 2 -> rgb1_g toggles between PWM-128 and off every 4 frames, starting on.
REQ-034 SHALL cover: areset asserted for 1 cycle at wcnt=77 -> outputs 0 the next cycle, wcnt restarts at 0, LEDs dark for the first frame.
REQ-035 SHALL cover: with RGB_LED_PWM_BREATHE_EN, mode 3 duty 0xFF -> frame k duty_eff = (255*ramp)>>8 (ramp 0,1,..,255,254,..); without the macro, constant duty 0xFF.
